// File: rtl/hp_tracker.sv
// Player HP counter with invincibility window, sticky game-over and an HP bar pixel.
// Optional HP_TRACKER_FLASH_EN: filled bar flashes white every 4th frame while invincible.
module hp_tracker #(
  parameter int unsigned X             = 480,
  parameter int unsigned Y             = 584,
  parameter int unsigned WIDTH         = 112,
  parameter int unsigned HEIGHT        = 32,
  parameter int unsigned MAX_HP        = 28,
  parameter int unsigned PX_PER_HP     = 4,
  parameter int unsigned DAMAGE        = 1,
  parameter int unsigned HEAL          = 4,
  parameter int unsigned IFRAME_CYCLES = 32500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        damage_in,
  input  logic        heal_in,
  output logic [7:0]  hp_out,
  output logic        invincible_out,
  output logic        game_over_out,
  output logic [11:0] pixel_out
);

  localparam logic [7:0]  MaxHp    = 8'(MAX_HP);
  localparam logic [7:0]  DmgHp    = 8'(DAMAGE);
  localparam logic [7:0]  HealHp   = 8'(HEAL);
  localparam logic [31:0] IfLast   = 32'(IFRAME_CYCLES - 1);
  localparam logic [11:0] PxW      = 12'(PX_PER_HP);
  localparam logic [11:0] XL       = 12'(X);
  localparam logic [11:0] XEnd     = 12'(X + WIDTH);
  localparam logic [11:0] YL       = 12'(Y);
  localparam logic [11:0] YEnd     = 12'(Y + HEIGHT);
  localparam logic [11:0] FullFill = 12'(MAX_HP * PX_PER_HP);

  typedef enum logic [1:0] {StAlive, StInvincible, StDead} state_e;

  state_e      state_q, state_d;
  logic [7:0]  hp_q, hp_d;
  logic [31:0] cnt_q, cnt_d;
  logic        dmg_q, dmg_prev_q, heal_q, heal_prev_q;
  logic        game_over_q;
  logic [11:0] fill_q, pixel_q, pixel_d;
  logic        hit, heal_edge;
  logic [8:0]  heal_sum;
  logic [7:0]  heal_val;
  logic [11:0] h12, v12, fill_color;
  logic        in_bar;

  assign hit       = dmg_q & ~dmg_prev_q;
  assign heal_edge = heal_q & ~heal_prev_q;
  assign heal_sum  = {1'b0, hp_q} + {1'b0, HealHp};
  assign heal_val  = (heal_sum > {1'b0, MaxHp}) ? MaxHp : heal_sum[7:0];

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    case (state_q)
      StAlive: begin
        // A hit shadows a simultaneous heal here
        if (hit) begin
          if (hp_q > DmgHp) begin
            hp_d    = hp_q - DmgHp;
            state_d = StInvincible;
            cnt_d   = '0;
          end else begin
            hp_d    = '0;
            state_d = StDead;
          end
        end else if (heal_edge) begin
          hp_d = heal_val;
        end
      end
      StInvincible: begin
        if (heal_edge) hp_d = heal_val;
        if (cnt_q == IfLast) begin
          state_d = StAlive;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDead: ;
      default: state_d = StAlive;
    endcase
  end

`ifdef HP_TRACKER_FLASH_EN
  logic [1:0] frame_cnt_q, frame_cnt_d;
  logic       flash_q, flash_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    flash_d     = flash_q;
    if (state_q != StInvincible) begin
      frame_cnt_d = '0;
      flash_d     = 1'b0;
    end else if (hcount_in == 11'd0 && vcount_in == 10'd0) begin
      frame_cnt_d = frame_cnt_q + 2'd1;
      if (frame_cnt_q == 2'd3) flash_d = ~flash_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt_q <= '0;
      flash_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      flash_q     <= flash_d;
    end
  end

  assign fill_color = flash_q ? 12'hFFF : 12'hFF0;
`else
  assign fill_color = 12'hFF0;
`endif

  assign h12    = {1'b0, hcount_in};
  assign v12    = {2'b0, vcount_in};
  assign in_bar = (h12 >= XL) && (h12 < XEnd) && (v12 >= YL) && (v12 < YEnd);

  always_comb begin
    pixel_d = 12'h000;
    if (in_bar) pixel_d = (h12 < XL + fill_q) ? fill_color : 12'hF00;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StAlive;
      hp_q        <= MaxHp;
      cnt_q       <= '0;
      dmg_q       <= 1'b0;
      dmg_prev_q  <= 1'b0;
      heal_q      <= 1'b0;
      heal_prev_q <= 1'b0;
      game_over_q <= 1'b0;
      fill_q      <= FullFill;
      pixel_q     <= '0;
    end else begin
      state_q     <= state_d;
      hp_q        <= hp_d;
      cnt_q       <= cnt_d;
      dmg_q       <= damage_in;
      dmg_prev_q  <= dmg_q;
      heal_q      <= heal_in;
      heal_prev_q <= heal_q;
      game_over_q <= (state_q == StDead);
      fill_q      <= {4'b0, hp_q} * PxW;
      pixel_q     <= pixel_d;
    end
  end

  assign hp_out         = hp_q;
  assign invincible_out = (state_q == StInvincible);
  assign game_over_out  = game_over_q;
  assign pixel_out      = pixel_q;

endmodule

// File: tb/tb_hp_tracker.sv
// Scoreboard bench for hp_tracker: directed stimulus pushes expectations, a negedge monitor
// pops and compares them against two instances (DAMAGE=1 and DAMAGE=5, short iframe window).
module tb_hp_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        damage_a, heal_a, damage_b, heal_b;
  logic [7:0]  hp_a, hp_b;
  logic        inv_a, inv_b, go_a, go_b;
  logic [11:0] pix_a, pix_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;
    logic [11:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [11:0] got;

  always #5 clk = ~clk;

  hp_tracker #(.IFRAME_CYCLES(100)) dut_a (
    .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount),
    .damage_in(damage_a), .heal_in(heal_a), .hp_out(hp_a),
    .invincible_out(inv_a), .game_over_out(go_a), .pixel_out(pix_a)
  );

  hp_tracker #(.DAMAGE(5), .IFRAME_CYCLES(100)) dut_b (
    .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount),
    .damage_in(damage_b), .heal_in(heal_b), .hp_out(hp_b),
    .invincible_out(inv_b), .game_over_out(go_b), .pixel_out(pix_b)
  );

  // Monitor: drain all pending expectations on every falling edge
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      case (cur.kind)
        0:       got = {4'b0, hp_a};
        1:       got = {11'b0, inv_a};
        2:       got = {11'b0, go_a};
        3:       got = pix_a;
        4:       got = {4'b0, hp_b};
        5:       got = {11'b0, go_b};
        default: got = {11'b0, inv_b};
      endcase
      checks++;
      if (got !== cur.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", cur.name, got, cur.val);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int kind, input logic [11:0] val, input string name);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic flush();
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic pix(input int h, input int v, input logic [11:0] val, input string name);
    hcount = 11'(h);
    vcount = 10'(v);
    step(1);
    expect_val(3, val, name);
    flush();
  endtask

  task automatic pulse_a(input logic d, input logic hl);
    damage_a = d;
    heal_a   = hl;
    step(1);
    damage_a = 1'b0;
    heal_a   = 1'b0;
    step(3);
  endtask

  task automatic pulse_b(input logic d, input logic hl);
    damage_b = d;
    heal_b   = hl;
    step(1);
    damage_b = 1'b0;
    heal_b   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    hcount = '0;
    vcount = '0;
    damage_a = 1'b0;
    heal_a = 1'b0;
    damage_b = 1'b0;
    heal_b = 1'b0;
    step(3);
    rst = 1'b1;
    step(1);
    expect_val(0, 12'd28, "reset_hp");
    expect_val(1, 12'd0, "reset_inv");
    expect_val(2, 12'd0, "reset_go");
    flush();
    pix(591, 600, 12'hFF0, "pix_full_last");
    pix(592, 600, 12'h000, "pix_full_outside");

    pulse_a(1'b1, 1'b0);
    expect_val(0, 12'd27, "hit_hp27");
    expect_val(1, 12'd1, "hit_inv");
    flush();
    pulse_a(1'b1, 1'b0);
    expect_val(0, 12'd27, "iframe_ignores_hit");
    flush();
    step(110);
    expect_val(1, 12'd0, "iframe_expired");
    flush();
    pulse_a(1'b1, 1'b0);
    expect_val(0, 12'd26, "hit_after_window");
    flush();
    step(110);
    pulse_a(1'b0, 1'b1);
    expect_val(0, 12'd28, "heal_saturate");
    flush();

    damage_a = 1'b1;
    step(500);
    damage_a = 1'b0;
    step(3);
    expect_val(0, 12'd27, "held_damage_once");
    flush();
    step(110);

    for (int i = 0; i < 17; i++) begin
      pulse_a(1'b1, 1'b0);
      step(105);
    end
    expect_val(0, 12'd10, "hp10");
    flush();
    pix(519, 590, 12'hFF0, "pix_hp10_filled");
    pix(520, 590, 12'hF00, "pix_hp10_empty");
    pix(480, 616, 12'h000, "pix_below_bar");

    pulse_a(1'b1, 1'b1);
    expect_val(0, 12'd9, "alive_hit_wins");
    flush();
    step(110);
    for (int i = 0; i < 7; i++) begin
      pulse_a(1'b1, 1'b0);
      step(105);
    end
    expect_val(0, 12'd2, "hp2");
    flush();
    pulse_a(1'b0, 1'b1);
    expect_val(0, 12'd6, "heal_hp6");
    flush();
    pulse_a(1'b1, 1'b0);
    pulse_a(1'b1, 1'b1);
    expect_val(0, 12'd9, "inv_heal_applies");
    expect_val(1, 12'd1, "inv_still");
    flush();

    for (int i = 0; i < 5; i++) begin
      pulse_b(1'b1, 1'b0);
      step(105);
    end
    expect_val(4, 12'd3, "b_hp3");
    expect_val(5, 12'd0, "b_alive");
    flush();
    pulse_b(1'b1, 1'b0);
    step(1);
    expect_val(4, 12'd0, "b_hp0");
    expect_val(5, 12'd0, "b_go_not_yet");
    flush();
    step(1);
    expect_val(5, 12'd1, "b_go_next_cycle");
    flush();
    pulse_b(1'b0, 1'b1);
    step(2);
    pulse_b(1'b1, 1'b0);
    step(3);
    expect_val(4, 12'd0, "b_dead_sticky_hp");
    expect_val(5, 12'd1, "b_dead_sticky_go");
    flush();
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    expect_val(4, 12'd28, "b_reset_hp");
    expect_val(5, 12'd0, "b_reset_go");
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hp_tracker.md
Name: hp_tracker

Overview:
- Player health stage directly upstream of the top-level game state machine; drop-in replacement for the current bar instance.
- Consumes damage pulses from the enemy bullet stage and heal pulses from the menu item path.
- Owns the HP counter, invincibility window and sticky game-over flag; renders the HP bar pixel the top level sums into the frame.

Parameters:
- X, 480, bar left edge (hcount)
- Y, 584, bar top edge (vcount)
- WIDTH, 112, bar width in pixels; must equal MAX_HP*PX_PER_HP
- HEIGHT, 32, bar height in pixels
- MAX_HP, 28, starting and maximum HP
- PX_PER_HP, 4, pixels per HP point
- DAMAGE, 1, HP removed per accepted hit
- HEAL, 4, HP restored per accepted heal
- IFRAME_CYCLES, 32500000, invincibility length in clk cycles (0.5 s at 65 MHz)

Ports:
- clk  input  1  pixel/system clock
- rst  input  1  synchronous, active-low reset
- hcount_in  input  11  current pixel column
- vcount_in  input  10  current pixel row
- damage_in  input  1  hit indication from enemy stage, level or pulse
- heal_in  input  1  heal request from menu stage, level or pulse
- hp_out  output  8  current HP
- invincible_out  output  1  high during invincibility window
- game_over_out  output  1  sticky, high once HP reaches 0
- pixel_out  output  12  RGB444 bar pixel, 0 outside bar

Behaviour:
- Reset (rst==0 at posedge clk):
  - hp_out=MAX_HP, invincible_out=0, game_over_out=0, pixel_out=0.
  - State ALIVE; edge registers cleared; iframe counter=0.
  - Reset mid-invincibility or in DEAD returns to ALIVE the next cycle.
- Edge detection:
  - damage_in and heal_in are registered.
  - A hit is damage_in==1 with previous sample 0; same rule for heal. Held levels count once.
- States:
  - ALIVE: on a hit, hp <= (hp>DAMAGE) ? hp-DAMAGE : 0.
    - Result 0 -> DEAD.
    - Otherwise -> INVINCIBLE with counter=0.
  - INVINCIBLE: hits ignored; counter increments each cycle; counter==IFRAME_CYCLES-1 -> ALIVE.
  - DEAD: game_over_out=1 from the cycle after hp becomes 0; hits and heals ignored until reset.
- Heal:
  - Accepted in ALIVE and INVINCIBLE: hp <= min(hp+HEAL, MAX_HP). Does not change state or counter.
  - Simultaneous hit and heal edge in ALIVE: the hit wins and the heal is dropped.
  - Simultaneous hit and heal edge in INVINCIBLE: the heal applies.
- Outputs: hp_out and invincible_out are registered, with 1 cycle latency from the edge sample.
- Pixel path:
  - fill = hp*PX_PER_HP, registered on the cycle after hp changes.
  - Inside bar = X<=hcount_in<X+WIDTH and Y<=vcount_in<Y+HEIGHT.
  - Inside bar and hcount_in<X+fill -> 12'hFF0; inside bar, unfilled -> 12'hF00; outside -> 12'h000.
  - pixel_out registered, 1 cycle after hcount_in/vcount_in.
- Width rules:
  - hp arithmetic is 8 bits with no wrap; saturation is explicit at 0 and MAX_HP.
  - Iframe counter is 32 bits.

Optional Feature:
- Macro: HP_TRACKER_FLASH_EN.
- Defined:
  - While INVINCIBLE, a flash bit toggles at each frame start (hcount_in==0 && vcount_in==0) on every 4th frame.
  - When the bit is 1, the filled region outputs 12'hFFF instead of 12'hFF0.
  - Flash bit clears on leaving INVINCIBLE and on reset.
- Undefined: no flash logic; the filled region is always 12'hFF0.

Test Plan:
- Reset release -> hp_out=28, game_over_out=0; pixel at (591,600)=12'hFF0; pixel at (592,600)=0.
- Single damage pulse -> hp_out=27, invincible_out=1 for 32500000 cycles. A second pulse inside the window leaves hp_out=27; the same pulse after the window gives hp_out=26. Bench uses IFRAME_CYCLES=100.
- damage_in held high 500 cycles (IFRAME_CYCLES=100) -> exactly one decrement.
- hp=2, heal pulse -> hp=6. hp=26, heal pulse -> hp=28 (saturates). Hit and heal edges in the same cycle while ALIVE at hp=10 -> hp=9.
- DAMAGE=5, hp=3, hit -> hp_out=0, game_over_out=1 next cycle. Further heals/hits leave hp_out=0. rst low one cycle -> hp_out=28, game_over_out=0.
- hp=10 -> pixel at (519,590)=12'hFF0, (520,590)=12'hF00, (480,616)=0. With HP_TRACKER_FLASH_EN during invincibility, the filled pixel alternates 12'hFFF/12'hFF0 every 4 frames.
